// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver using a 16x oversampling strobe.
// Waits for a start edge, confirms it at the start-bit midpoint, samples each
// data bit at its midpoint (LSB first), and checks the stop bit at its midpoint.
// A good frame loads rx_data and pulses rx_done. A bad start or stop bit is dropped.
//
// Optional feature: define UART_RX_SYNC_EN to pass rx through a 2-flop
// synchroniser before the FSM. The synchroniser resets to idle-high.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   s_tick   in   oversampling strobe, one clk wide, 16 per bit period
//   rx       in   serial line, idle high
//   rx_data  out  last good byte; changes only in the rx_done cycle
//   rx_done  out  one-clock pulse when a good byte is on rx_data
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;

  // Two-flop synchroniser. It resets high so reset does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];
`else
  assign rx_s = rx;
`endif

  // Receive FSM with its tick counter, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        // The start edge is caught on any clock, without waiting for a tick.
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end

        // Re-check the line at the start-bit midpoint to reject glitches.
        START: begin
          if (s_tick) begin
            if (s == SW'(7)) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        // Sample one bit period after the previous midpoint. Bits arrive LSB
        // first, so each new bit enters at the MSB.
        DATA: begin
          if (s_tick) begin
            if (s == SW'(15)) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == NW'(DBIT - 1)) begin
                state <= STOP;
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        // Leave at the stop-bit midpoint. This gives time to catch the next start edge.
        STOP: begin
          if (s_tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              state <= IDLE;
              s     <= '0;
              if (rx_s) begin
                rx_data <= b;
                rx_done <= 1'b1;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Frames come from a vector table, with hand-written glitch
// and mid-frame reset sequences. Expected bytes are queued when a frame is
// driven. A monitor pops and checks them on each rx_done.
module tb_uart_rx;

  localparam int unsigned DBIT     = 8;
  localparam int unsigned SB_TICK  = 16;
  localparam int unsigned BIT_CLKS = 64;

  logic            clk;
  logic            rst_n;
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] rx_data;
  logic            rx_done;

  uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_tick  (s_tick),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_done (rx_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         gap;
  } vec_t;

  int         compared   = 0;
  int         mismatched = 0;
  int         done_cnt   = 0;
  int         push_cnt   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] last_good  = 8'h00;
  logic [1:0] tcnt       = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_tick fires once every 4 clocks.
  initial s_tick = 1'b0;
  always @(negedge clk) begin
    tcnt   = tcnt + 2'd1;
    s_tick = (tcnt == 2'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor. Each rx_done pops one expected byte. Outside
  // rx_done, rx_data must hold its value.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_data = rx_data;
    end else begin
      if (rx_done === 1'b1) begin
        done_cnt++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_done: got rx_data %h expected no pulse at %0t", rx_data, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            mismatched++;
            $display("FAIL rx_data_on_done: got %h expected %h at %0t", rx_data, e, $time);
          end
        end
      end else begin
        compared++;
        if (rx_data !== prev_data) begin
          mismatched++;
          $display("FAIL rx_data_hold: got %h expected %h at %0t", rx_data, prev_data, $time);
        end
      end
      prev_data = rx_data;
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // A bad stop bit is held low only long enough to cover its midpoint. The
  // line is then released, so the retriggered start check sees idle again.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int gap);
    if (stop_ok) begin
      exp_q.push_back(d);
      push_cnt++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (stop_ok) begin
      drive_bit(1'b1);
    end else begin
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{data: 8'h37, stop_ok: 1'b1, gap: 20};
    vecs[1] = '{data: 8'hA5, stop_ok: 1'b1, gap: 20};
    vecs[2] = '{data: 8'h5A, stop_ok: 1'b0, gap: 20};
    vecs[3] = '{data: 8'h3C, stop_ok: 1'b1, gap: 20};
    vecs[4] = '{data: 8'h00, stop_ok: 1'b1, gap: 0};
    vecs[5] = '{data: 8'hFF, stop_ok: 1'b1, gap: 0};
    vecs[6] = '{data: 8'h81, stop_ok: 1'b1, gap: 40};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      // Glitch after 0xA5: low for 3 ticks, then idle for two bit times.
      if (i == 2) begin
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_rx_data", 32'(rx_data), 32'(last_good));
      end
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].gap);
      if (vecs[i].stop_ok) last_good = vecs[i].data;
      check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(last_good));
    end

    // Reset during data bit 4 of a frame. The frame is aborted and the outputs clear.
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_rx_done", 32'(rx_done), 32'h0);
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("post_reset_idle_rx_data", 32'(rx_data), 32'h0);

    send_frame(8'hC3, 1'b1, 40);
    last_good = 8'hC3;
    check("final_rx_data", 32'(rx_data), 32'(last_good));

    repeat (200) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    check("done_count", 32'(done_cnt), 32'(push_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
